// File: rtl/fila_pkg.sv
// Shared definitions for the fila queue and its front-end controller.
package fila_pkg;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PUSH     = 2'd1,
        POP      = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_ENQ  = 2'd1,
        REQ_DEQ  = 2'd2,
        REQ_BOTH = 2'd3
    } req_t;

    // Folds the two one-cycle request pulses into a single decision code.
    function automatic req_t classify_req(input logic enq, input logic deq);
        req_t r;
        case ({enq, deq})
            2'b10:   r = REQ_ENQ;
            2'b01:   r = REQ_DEQ;
            2'b11:   r = REQ_BOTH;
            default: r = REQ_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/debounce.sv
// Push-button conditioner: 2-flop synchroniser followed by a stability counter
// that only lets the debounced level follow after DEBOUNCE_CYCLES equal samples.
module debounce #(
    parameter int DEBOUNCE_CYCLES = 200
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic level_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc_s;

    assign cnt_inc_s = cnt_q + CNT_ONE;

    // The level flips on the sample that brings the run of differing samples to DEBOUNCE_CYCLES.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_inc_s == CNT_MAX) begin
            level_d = ~level_q;
            cnt_d   = CNT_ZERO;
        end else begin
            cnt_d = cnt_inc_s;
        end
    end

    // Synchroniser, counter and debounced level registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= CNT_ZERO;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/controle_fila.sv
// Front-end for the fila queue: turns bouncing buttons and raw switches into
// clean single-cycle push/pop strobes, refusing pushes when full and pops when empty.
module controle_fila #(
    parameter int DATA_W          = fila_pkg::DATA_W,
    parameter int LEN_W           = fila_pkg::LEN_W,
    parameter int FULL_LEN        = 7,
    parameter int DEBOUNCE_CYCLES = 200
) (
    input  logic              clk_10KHz,
    input  logic              reset,
    input  logic [DATA_W-1:0] sw_in,
    input  logic              btn_enq_in,
    input  logic              btn_deq_in,
    input  logic [LEN_W-1:0]  len_in,
    output logic [DATA_W-1:0] data_out,
    output logic              enqueue_out,
    output logic              dequeue_out,
    output logic              reject_out
);

    import fila_pkg::*;

    localparam logic [LEN_W-1:0] FULL_LEN_C  = LEN_W'(FULL_LEN);
    localparam logic [LEN_W-1:0] EMPTY_LEN_C = {LEN_W{1'b0}};

    logic [DATA_W-1:0] sw_s1_q;
    logic [DATA_W-1:0] sw_s2_q;
    logic [DATA_W-1:0] data_q;
    logic              enq_lvl_s;
    logic              deq_lvl_s;
    logic              enq_prev_q;
    logic              deq_prev_q;
    logic              enq_req_q;
    logic              deq_req_q;
    req_t              req_s;
    state_t            state_q;
    logic              enq_q;
    logic              deq_q;
    logic              rej_q;

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_enq (
        .clk_i  (clk_10KHz),
        .reset_i(reset),
        .btn_i  (btn_enq_in),
        .level_o(enq_lvl_s)
    );

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_deq (
        .clk_i  (clk_10KHz),
        .reset_i(reset),
        .btn_i  (btn_deq_in),
        .level_o(deq_lvl_s)
    );

    // Switch bank synchroniser.
    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            sw_s1_q <= {DATA_W{1'b0}};
            sw_s2_q <= {DATA_W{1'b0}};
        end else begin
            sw_s1_q <= sw_in;
            sw_s2_q <= sw_s1_q;
        end
    end

    // Rising-edge detection of the debounced levels into one-cycle requests.
    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            enq_prev_q <= 1'b0;
            deq_prev_q <= 1'b0;
            enq_req_q  <= 1'b0;
            deq_req_q  <= 1'b0;
        end else begin
            enq_prev_q <= enq_lvl_s;
            deq_prev_q <= deq_lvl_s;
            enq_req_q  <= enq_lvl_s & ~enq_prev_q;
            deq_req_q  <= deq_lvl_s & ~deq_prev_q;
        end
    end

    assign req_s = classify_req(enq_req_q, deq_req_q);

    // Request FSM; strobes are registered on the transition so each lasts exactly one cycle.
    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= {DATA_W{1'b0}};
            enq_q   <= 1'b0;
            deq_q   <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            enq_q <= 1'b0;
            deq_q <= 1'b0;
            rej_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    case (req_s)
                        REQ_ENQ: begin
                            if (len_in == FULL_LEN_C) begin
                                rej_q   <= 1'b1;
                                state_q <= WAIT_REL;
                            end else begin
                                enq_q   <= 1'b1;
                                data_q  <= sw_s2_q;
                                state_q <= PUSH;
                            end
                        end
                        REQ_DEQ: begin
                            if (len_in == EMPTY_LEN_C) begin
                                rej_q   <= 1'b1;
                                state_q <= WAIT_REL;
                            end else begin
                                deq_q   <= 1'b1;
                                state_q <= POP;
                            end
                        end
                        REQ_BOTH: begin
                            rej_q   <= 1'b1;
                            state_q <= WAIT_REL;
                        end
                        default: state_q <= IDLE;
                    endcase
                end
                PUSH:     state_q <= WAIT_REL;
                POP:      state_q <= WAIT_REL;
                // Also covers the queue's len_in update latency before the next decision.
                WAIT_REL: begin
                    if (!enq_lvl_s && !deq_lvl_s) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= WAIT_REL;
                    end
                end
                default:  state_q <= IDLE;
            endcase
        end
    end

    assign data_out    = data_q;
    assign enqueue_out = enq_q;
    assign dequeue_out = deq_q;
    assign reject_out  = rej_q;

endmodule

// File: tb/tb_controle_fila.sv
// Directed bench for controle_fila with DEBOUNCE_CYCLES = 4.
module tb_controle_fila;

    import fila_pkg::*;

    localparam int DB   = 4;
    localparam int LAT  = DB + 3;
    localparam int HOLD = 20;
    localparam int NVEC = 8;

    typedef struct {
        logic [7:0] sw;
        logic [2:0] len;
        logic       enq;
        logic       deq;
        int         exp_enq;
        int         exp_deq;
        int         exp_rej;
        logic [7:0] exp_data;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [7:0] sw;
    logic       btn_enq;
    logic       btn_deq;
    logic [2:0] len;
    logic [7:0] data_o;
    logic       enq_o;
    logic       deq_o;
    logic       rej_o;

    int n_cmp;
    int n_bad;

    vec_t vecs [NVEC];

    controle_fila #(
        .DATA_W         (8),
        .LEN_W          (3),
        .FULL_LEN       (7),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk_10KHz  (clk),
        .reset      (reset),
        .sw_in      (sw),
        .btn_enq_in (btn_enq),
        .btn_deq_in (btn_deq),
        .len_in     (len),
        .data_out   (data_o),
        .enqueue_out(enq_o),
        .dequeue_out(deq_o),
        .reject_out (rej_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int ne;
        int nd;
        int nr;
        int first;
        int overlap;
        int active;
        ne = 0; nd = 0; nr = 0; first = -1; overlap = 0;
        sw  = v.sw;
        len = v.len;
        repeat (3) step();
        btn_enq = v.enq;
        btn_deq = v.deq;
        for (int c = 0; c < HOLD + 12; c++) begin
            if (c == HOLD) begin
                btn_enq = 1'b0;
                btn_deq = 1'b0;
            end
            step();
            active = int'(enq_o) + int'(deq_o) + int'(rej_o);
            if (enq_o) ne++;
            if (deq_o) nd++;
            if (rej_o) nr++;
            if (active > 1) overlap++;
            if (first < 0 && active > 0) first = c;
        end
        check($sformatf("vec%0d enqueue_count", idx), ne, v.exp_enq);
        check($sformatf("vec%0d dequeue_count", idx), nd, v.exp_deq);
        check($sformatf("vec%0d reject_count", idx), nr, v.exp_rej);
        check($sformatf("vec%0d latency", idx), first, LAT);
        check($sformatf("vec%0d overlap", idx), overlap, 0);
        check($sformatf("vec%0d data_out", idx), int'(data_o), int'(v.exp_data));
        check($sformatf("vec%0d back_to_idle", idx), int'(dut.state_q), int'(IDLE));
    endtask

    initial begin
        int ne;
        int nr;
        int found;
        int first;

        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b1;
        sw      = 8'hA7;
        btn_enq = 1'b0;
        btn_deq = 1'b0;
        len     = 3'd0;

        // sw, len, enq, deq, exp_enq, exp_deq, exp_rej, exp_data
        vecs[0] = '{8'h5A, 3'd0, 1'b1, 1'b0, 1, 0, 0, 8'h5A};
        vecs[1] = '{8'hA5, 3'd7, 1'b1, 1'b0, 0, 0, 1, 8'h5A};
        vecs[2] = '{8'h33, 3'd0, 1'b0, 1'b1, 0, 0, 1, 8'h5A};
        vecs[3] = '{8'h33, 3'd3, 1'b0, 1'b1, 0, 1, 0, 8'h5A};
        vecs[4] = '{8'hC3, 3'd6, 1'b1, 1'b0, 1, 0, 0, 8'hC3};
        vecs[5] = '{8'h11, 3'd2, 1'b1, 1'b1, 0, 0, 1, 8'hC3};
        vecs[6] = '{8'hFF, 3'd7, 1'b0, 1'b1, 0, 1, 0, 8'hC3};
        vecs[7] = '{8'h00, 3'd1, 1'b1, 1'b0, 1, 0, 0, 8'h00};

        repeat (3) step();
        check("reset data_out", int'(data_o), 0);
        check("reset enqueue_out", int'(enq_o), 0);
        check("reset dequeue_out", int'(deq_o), 0);
        check("reset reject_out", int'(rej_o), 0);
        check("reset state", int'(dut.state_q), int'(IDLE));
        reset = 1'b0;
        sw    = 8'h00;
        repeat (3) step();

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, vecs[i]);
        end

        // Bounce: toggling every 2 cycles never gives 4 stable samples.
        ne = 0; nr = 0;
        sw  = 8'h99;
        len = 3'd0;
        for (int c = 0; c < 30; c++) begin
            btn_enq = (c < 12) ? (((c / 2) % 2) == 0) : 1'b0;
            step();
            if (enq_o || deq_o) ne++;
            if (rej_o) nr++;
        end
        check("bounce strobes", ne, 0);
        check("bounce rejects", nr, 0);
        check("bounce data_out", int'(data_o), 8'h00);

        // Reset asserted during the PUSH strobe cycle, button kept held.
        sw  = 8'h77;
        len = 3'd2;
        repeat (3) step();
        btn_enq = 1'b1;
        found = 0;
        for (int c = 0; c < 30; c++) begin
            if (found == 0) begin
                step();
                if (enq_o) found = 1;
            end
        end
        check("rst_strobe seen", found, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_strobe enqueue_out", int'(enq_o), 0);
        check("rst_strobe dequeue_out", int'(deq_o), 0);
        check("rst_strobe reject_out", int'(rej_o), 0);
        check("rst_strobe data_out", int'(data_o), 0);
        check("rst_strobe state", int'(dut.state_q), int'(IDLE));
        first = -1; ne = 0;
        for (int c = 0; c < HOLD; c++) begin
            step();
            if (enq_o) begin
                ne++;
                if (first < 0) first = c;
            end
        end
        check("rst_strobe relatency", first, LAT);
        check("rst_strobe repush_count", ne, 1);
        check("rst_strobe data_out after", int'(data_o), 8'h77);
        btn_enq = 1'b0;
        repeat (12) step();
        check("rst_strobe back_to_idle", int'(dut.state_q), int'(IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
